seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/seg7_bin2bcd.sv | 77 +++++++
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment codes, BCD digit type and converter state encoding for the seg7 scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // ceil(bin_w * log10(2)) + 1, in integer arithmetic.
    function automatic int bcd_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000 + 1;
    endfunction

    function automatic logic [6:0] seg_of(input bcd_t d);
        case (d)
            4'd0:    seg_of = SEG_0;
            4'd1:    seg_of = SEG_1;
            4'd2:    seg_of = SEG_2;
            4'd3:    seg_of = SEG_3;
            4'd4:    seg_of = SEG_4;
            4'd5:    seg_of = SEG_5;
            4'd6:    seg_of = SEG_6;
            4'd7:    seg_of = SEG_7;
            4'd8:    seg_of = SEG_8;
            4'd9:    seg_of = SEG_9;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble: start captures bin, busy for BIN_W cycles, then one cycle of done.
// No backpressure: start is ignored while shifting; bcd holds the result until the next start.
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int BIN_W = 14,
    parameter int BCD_D = bcd_digits(BIN_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_D*4-1:0] bcd
);

    localparam int CNT_W = $clog2(BIN_W);

    conv_state_t        state_q, state_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [BCD_D*4-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_D; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            CONV_SHIFT: begin
                {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = CONV_DONE;
                end
            end
            CONV_DONE: state_d = CONV_IDLE;
            default:   ;
        endcase
        // A new request may overlap the done cycle; bcd_q is still valid on that edge.
        if (start && (state_q != CONV_SHIFT)) begin
            state_d = CONV_SHIFT;
            sh_d    = bin;
            bcd_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == CONV_SHIFT);
    assign done = (state_q == CONV_DONE);
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: load converts value to BCD (BIN_W+1 cycles to display), scan steps every REFRESH_DIV cycles.
// load is dropped while busy. Define SEG7_LZ_BLANK_EN to blank leading zeros.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BIN_W-1:0]    value,
    input  logic                load,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic                busy,
    output logic                overflow
);

    localparam int BCD_D = bcd_digits(BIN_W);
    localparam int MAX_D = (BCD_D > N_DIGITS) ? BCD_D : N_DIGITS;
    localparam int EXT_W = MAX_D * 4;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);

    logic               conv_busy, conv_done;
    logic [BCD_D*4-1:0] conv_bcd;
    logic [EXT_W-1:0]   bcd_ext;

    bcd_t [N_DIGITS-1:0] digits_q, digits_d;
    logic                overflow_q, overflow_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                live_q, live_d;
    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [N_DIGITS-1:0] lz;
    logic                tick;

    seg7_bin2bcd #(.BIN_W(BIN_W), .BCD_D(BCD_D)) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (load && !conv_busy),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign bcd_ext = EXT_W'(conv_bcd);

    // Digits above the display width only feed the overflow flag.
    always_comb begin
        digits_d   = digits_q;
        overflow_d = overflow_q;
        if (conv_done) begin
            overflow_d = 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                digits_d[i] = bcd_ext[i*4 +: 4];
            end
            for (int i = N_DIGITS; i < MAX_D; i++) begin
                if (bcd_ext[i*4 +: 4] != 4'd0) overflow_d = 1'b1;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic lz_run;
    always_comb begin
        lz     = '0;
        lz_run = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            if (digits_q[i] != 4'd0) lz_run = 1'b0;
            lz[i] = lz_run;
        end
    end
`else
    assign lz = '0;
`endif

    // live_q stays low until the first tick so an remains dark right after reset.
    always_comb begin
        tick   = (div_q == DIV_W'(REFRESH_DIV - 1));
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        live_d = live_q || tick;
        idx_d  = idx_q;
        if (tick && live_q) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (live_d) begin
            an_d = ~(N_DIGITS'(1) << idx_d);
            if (overflow_q)      seg_d = SEG_DASH;
            else if (lz[idx_d])  seg_d = SEG_BLANK;
            else                 seg_d = seg_of(digits_q[idx_d]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q   <= '0;
            overflow_q <= 1'b0;
            div_q      <= '0;
            idx_q      <= '0;
            live_q     <= 1'b0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
        end else begin
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            live_q     <= live_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign busy     = conv_busy;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected digit codes are queued per load, a monitor checks each scan slot.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int BW = 14;
    localparam int RD = 4;

    localparam logic [6:0] T_BLANK = 7'b1111111;
    localparam logic [6:0] T_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_TBL [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [BW-1:0] value;
    logic [6:0]    seg;
    logic [N-1:0]  an;
    logic          busy;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic                ovf;
        logic [N-1:0][6:0]   segs;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_active = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.N_DIGITS(N), .BIN_W(BW), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .seg      (seg),
        .an       (an),
        .busy     (busy),
        .overflow (overflow)
    );

    function automatic exp_t model(input int v);
        exp_t e;
        int   lim;
        int   pw;
        lim = 1;
        for (int i = 0; i < N; i++) lim *= 10;
        e.ovf = (v > lim - 1);
        pw = 1;
        for (int i = 0; i < N; i++) begin
            if (e.ovf) e.segs[i] = T_DASH;
`ifdef SEG7_LZ_BLANK_EN
            else if (i > 0 && v < pw) e.segs[i] = T_BLANK;
`endif
            else e.segs[i] = SEG_TBL[(v / pw) % 10];
            pw *= 10;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic scan_check(input exp_t e);
        logic [N-1:0] seen;
        logic [N-1:0] pat;
        seen = '0;
        repeat (2) @(negedge clk);
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        for (int k = 0; k < 3 * N * RD + 8 && seen != '1; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                pat = ~(N'(1) << i);
                if (an == pat && !seen[i]) begin
                    seen[i] = 1'b1;
                    check($sformatf("seg_digit%0d", i), {25'd0, seg}, {25'd0, e.segs[i]});
                end
            end
        end
        if (seen != '1) begin
            checks++;
            failures++;
            $display("FAIL scan_timeout seen=%b required=%b", seen, {N{1'b1}});
        end
    endtask

    // Output event: conversion finished, or reset released (display falls back to 0).
    initial begin : monitor
        logic busy_prev;
        logic rst_prev;
        exp_t e;
        busy_prev = 1'b0;
        rst_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && ((busy_prev && !busy) || !rst_prev)) begin
                busy_prev = busy;
                rst_prev  = rst_n;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_update busy=%b overflow=%b", busy, overflow);
                end else begin
                    mon_active = 1'b1;
                    e = sb_q.pop_front();
                    scan_check(e);
                    mon_active = 1'b0;
                end
            end
            busy_prev = busy;
            rst_prev  = rst_n;
        end
    end

    // Scan order: first lit digit is 0, then strictly +1 modulo N, always one-hot low.
    initial begin : an_mon
        int prev;
        int idx;
        prev = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = -1;
            end else if (an != '1 || prev >= 0) begin
                idx = -1;
                for (int i = 0; i < N; i++) if (an == ~(N'(1) << i)) idx = i;
                if (idx != prev) begin
                    check("an_sequence", idx, (prev < 0) ? 0 : (prev + 1) % N);
                    prev = idx;
                end
            end
        end
    end

    task automatic pulse_load(input int v);
        @(negedge clk);
        value = BW'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 600) begin
            @(posedge clk);
            if (sb_q.size() == 0 && !mon_active) break;
            n++;
        end
        if (n >= 600) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout pending=%0d required=0", sb_q.size());
        end
    endtask

    task automatic load_and_check(input int v);
        sb_q.push_back(model(v));
        pulse_load(v);
        wait_idle();
    endtask

    initial begin : stim
        int n;
        int v;
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, seg}, {25'd0, T_BLANK});
        check("rst_an", {28'd0, an}, {28'd0, {N{1'b1}}});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        sb_q.push_back(model(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= RD; i++) begin
            @(posedge clk);
            #1;
            if (i == RD - 1) check("an_dark_before_tick", {28'd0, an}, {28'd0, {N{1'b1}}});
            if (i == RD)     check("an_lit_at_tick", {31'd0, (an != '1)}, 32'd1);
        end
        wait_idle();

        sb_q.push_back(model(1234));
        pulse_load(1234);
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, BW);
        wait_idle();

        load_and_check(7);
        load_and_check(10000);
        load_and_check(9999);
        load_and_check(0);

        sb_q.push_back(model(42));
        pulse_load(42);
        repeat (2) @(negedge clk);
        check("busy_at_second_load", {31'd0, busy}, 32'd1);
        pulse_load(99);
        wait_idle();

        pulse_load(5555);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_seg", {25'd0, seg}, {25'd0, T_BLANK});
        check("abort_an", {28'd0, an}, {28'd0, {N{1'b1}}});
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        sb_q.push_back(model(0));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_idle();
        check("busy_after_abort", {31'd0, busy}, 32'd0);

        for (int r = 0; r < 12; r++) begin
            v = int'($urandom_range(0, (1 << BW) - 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            load_and_check(v);
        end

        repeat (2 * N * RD) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
